vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz master clock, advancing one pixel per pix_en strobe from the clock divider.
- Produces the hsync/vsync pins, pixel coordinates, a video-active flag and line/frame strobes.
- Downstream consumers are the pixel colour mux, the sprite renderers and the game-actor update logic, which use frame_start.
- Single clock domain (clk); pix_en is a 1-in-4 clock enable, not a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CW, 10, width of hcount/vcount

Ports:
- clk  in  1  100 MHz master clock
- rst  in  1  reset, synchronous, active-high
- pix_en  in  1  one-clk pixel strobe (25 MHz rate); all state advances only when high
- hcount  out  CW  current pixel column, 0..H_TOTAL-1
- vcount  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- video_on  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
- line_end  out  1  one-clk pulse on the pixel-advance that leaves column H_TOTAL-1
- frame_start  out  1  one-clk pulse on the pixel-advance that enters (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Every output is a flop. hsync, vsync and video_on are decoded from the next counter values, so they are cycle-aligned with hcount/vcount. There is zero added latency.
- Reset values (rst high on a clk edge, regardless of pix_en):
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1
  - hsync=vsync=~SYNC_POL (inactive)
  - video_on=0, line_end=0, frame_start=0
  - These values are consistent with the decode at (799,524).
- pix_en=0: counters, hsync, vsync and video_on hold. line_end and frame_start are 0.
- pix_en=1, horizontal counter:
  - hcount<H_TOTAL-1: increment.
  - hcount==H_TOTAL-1: wrap to 0, and the vertical counter advances.
- Vertical counter (advances only on the horizontal wrap):
  - vcount<V_TOTAL-1: increment.
  - vcount==V_TOTAL-1: wrap to 0.
- hsync is at active level iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is at active level iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- line_end=1 for exactly the clk in which hcount wraps 799->0. frame_start=1 for exactly the clk in which (hcount,vcount) becomes (0,0). Both pulses last one clk (10 ns), not one pixel.
- First pix_en after reset yields (0,0), video_on=1, frame_start=1 and line_end=1.
- rst mid-frame: all state returns to reset values on that edge. No partial pulses are emitted.
- rst and pix_en high together: rst wins.
- Counters never exceed TOTAL-1. Any out-of-range value is unreachable.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_*/V_*)
  - derived H_TOTAL/V_TOTAL and sync start/end positions
  - CW
- One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical).
  - Parameters: ACTIVE, FP, SYNC, BP, SYNC_POL.
  - Inputs: clk, rst, adv.
  - Outputs: count, sync, active, wrap.
  - Horizontal instance: adv=pix_en.
  - Vertical instance: adv=pix_en & horizontal wrap.
- The top level combines the active flags and generates the strobes.

Test Plan:
- Reset then pix_en every 4th clk: first advance gives hcount=0, vcount=0, video_on=1, frame_start=1 and line_end=1, each for one clk. Then hcount steps by 1 per strobe.
- Run one full line: hsync falls at hcount=656 and rises at 752 (96 strobes low). video_on drops at hcount=640. line_end pulses at the 799->0 wrap and vcount goes to 1.
- Run a full frame (420000 strobes): vsync is low for vcount 490..491 only. frame_start pulses exactly once per 420000 strobes. vcount wraps 524->0.
- Hold pix_en=0 for 100 clks mid-line at hcount=300: all outputs are frozen and no strobes fire. Resumes at 301.
- Assert rst at hcount=700, vcount=200 (inside hsync), with pix_en high in the same cycle: the next cycle shows (799,524), hsync=1, vsync=1, video_on=0 and no pulses.
- pix_en held constantly high (stress): the frame period is 420000 clk and sync positions are unchanged. Confirms there is no dependence on the 1-in-4 spacing.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants and the values derived from them.
package vga_timing_pkg;

  // Counter width for both axes (enough for 0..799 and 0..524).
  localparam int CW = 10;

  // Horizontal timing in pixels.
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  // Vertical timing in lines.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Sync active level: 0 means the pulse is driven low.
  localparam bit SYNC_POL = 1'b0;

  // Derived totals and sync windows (start inclusive, end exclusive).
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with a registered sync output.
// 'active' and 'wrap' describe the value the counter takes on the coming edge,
// so the parent can build flops that stay aligned with 'count'.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          active,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST       = CW'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);

  logic [CW-1:0] count_q, count_d;
  logic          sync_q, sync_d;

  // Next position, wrap flag and decodes taken from the next position.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (adv) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
    sync_d = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    active = (count_d < ACT_END);
  end

  // Position and sync registers; reset parks on the last position of the axis.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= LAST;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal and vertical axis counters advanced by the
// pixel strobe, plus registered video-active and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_start
);

  logic h_wrap, v_wrap, h_active, v_active, v_adv;
  logic video_on_q, line_end_q, frame_start_q;

  // The vertical axis steps only on the pixel that wraps the line.
  assign v_adv = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .adv(pix_en),
    .count(hcount), .sync(hsync), .active(h_active), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .adv(v_adv),
    .count(vcount), .sync(vsync), .active(v_active), .wrap(v_wrap)
  );

  // Video-active and one-clk strobes registered from the next-position decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      video_on_q    <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      video_on_q    <= h_active & v_active;
      line_end_q    <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  assign video_on    = video_on_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a full-size instance and a tiny-raster instance share one stimulus.
// A position model (advance count mod frame size) predicts every output each clk.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic [9:0] hcount_b, vcount_b, hcount_s, vcount_s;
  logic hsync_b, vsync_b, video_on_b, line_end_b, frame_start_b;
  logic hsync_s, vsync_s, video_on_s, line_end_s, frame_start_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .line_end(line_end_b), .frame_start(frame_start_b)
  );

  // Tiny raster (15x8 positions) with active-high sync so many frames fit in the run.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_on_s), .line_end(line_end_s), .frame_start(frame_start_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after n advances since reset; adv says the last edge advanced.
  function automatic logic [24:0] model(input longint n, input bit adv,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb, input bit pol);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    longint tot = longint'(ht) * longint'(vt);
    longint p = (n + tot - 1) % tot;
    int h = int'(p % ht);
    int v = int'(p / ht);
    bit hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    bit vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    bit von = (h < ha) && (v < va);
    bit le = adv && (h == 0);
    bit fs = adv && (h == 0) && (v == 0);
    return {10'(h), 10'(v), hsy, vsy, von, le, fs};
  endfunction

  task automatic cmp_dut(input string tag, input logic [24:0] act, input logic [24:0] exp);
    chk({tag, ".hcount"},      32'(act[24:15]), 32'(exp[24:15]));
    chk({tag, ".vcount"},      32'(act[14:5]),  32'(exp[14:5]));
    chk({tag, ".hsync"},       32'(act[4]),     32'(exp[4]));
    chk({tag, ".vsync"},       32'(act[3]),     32'(exp[3]));
    chk({tag, ".video_on"},    32'(act[2]),     32'(exp[2]));
    chk({tag, ".line_end"},    32'(act[1]),     32'(exp[1]));
    chk({tag, ".frame_start"}, 32'(act[0]),     32'(exp[0]));
  endtask

  // Model update on each edge, then compare both instances just after it.
  longint n_adv = 0;
  bit adv_last = 1'b0;
  bit armed = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      n_adv = 0;
      adv_last = 1'b0;
      armed = 1'b1;
    end else if (pix_en) begin
      n_adv++;
      adv_last = 1'b1;
    end else begin
      adv_last = 1'b0;
    end
    #1;
    if (armed) begin
      cmp_dut("big", {hcount_b, vcount_b, hsync_b, vsync_b, video_on_b, line_end_b, frame_start_b},
              model(n_adv, adv_last, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      cmp_dut("small", {hcount_s, vcount_s, hsync_s, vsync_s, video_on_s, line_end_s, frame_start_s},
              model(n_adv, adv_last, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1));
    end
  end

  // Drive inputs for one edge and return just after that edge.
  task automatic tick(input logic pe, input logic r);
    @(negedge clk);
    pix_en = pe;
    rst = r;
    @(posedge clk);
    #2;
  endtask

  // mode 0: strobe every 4th clk, 1: random strobes, 2: strobe every clk.
  task automatic adv_to(input int h, input int v, input int mode);
    int guard = 0;
    while (!(hcount_b == 10'(h) && vcount_b == 10'(v)) && guard < 5000) begin
      guard++;
      if (mode == 0) begin
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      end else if (mode == 1) begin
        tick($urandom_range(0, 3) == 0, 1'b0);
      end else begin
        tick(1'b1, 1'b0);
      end
    end
    chk($sformatf("reach(%0d,%0d)", h, v), 32'(hcount_b == 10'(h) && vcount_b == 10'(v)), 32'd1);
  endtask

  initial begin
    // Reset, including a cycle with pix_en high: reset must win.
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("rst.hcount", 32'(hcount_b), 32'd799);
    chk("rst.vcount", 32'(vcount_b), 32'd524);
    chk("rst.hsync", 32'(hsync_b), 32'd1);
    chk("rst.vsync", 32'(vsync_b), 32'd1);
    chk("rst.video_on", 32'(video_on_b), 32'd0);
    chk("rst.pulses", 32'({line_end_b, frame_start_b}), 32'd0);
    chk("rst_s.hcount", 32'(hcount_s), 32'd14);
    chk("rst_s.vcount", 32'(vcount_s), 32'd7);
    chk("rst_s.syncs", 32'({hsync_s, vsync_s}), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    chk("idle.hcount", 32'(hcount_b), 32'd799);

    // First advance lands on (0,0) with both strobes.
    tick(1'b1, 1'b0);
    chk("first.hcount", 32'(hcount_b), 32'd0);
    chk("first.vcount", 32'(vcount_b), 32'd0);
    chk("first.video_on", 32'(video_on_b), 32'd1);
    chk("first.frame_start", 32'(frame_start_b), 32'd1);
    chk("first.line_end", 32'(line_end_b), 32'd1);
    tick(1'b0, 1'b0);
    chk("first+1.pulses", 32'({line_end_b, frame_start_b}), 32'd0);
    chk("first+1.hcount", 32'(hcount_b), 32'd0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);

    // Line 0 boundaries at 1-in-4 strobes.
    adv_to(639, 0, 0);
    chk("h639.video_on", 32'(video_on_b), 32'd1);
    adv_to(640, 0, 0);
    chk("h640.video_on", 32'(video_on_b), 32'd0);
    adv_to(655, 0, 0);
    chk("h655.hsync", 32'(hsync_b), 32'd1);
    adv_to(656, 0, 0);
    chk("h656.hsync", 32'(hsync_b), 32'd0);
    adv_to(751, 0, 0);
    chk("h751.hsync", 32'(hsync_b), 32'd0);
    adv_to(752, 0, 0);
    chk("h752.hsync", 32'(hsync_b), 32'd1);
    adv_to(799, 0, 0);
    chk("h799.line_end", 32'(line_end_b), 32'd0);
    tick(1'b1, 1'b0);
    chk("wrap.hcount", 32'(hcount_b), 32'd0);
    chk("wrap.vcount", 32'(vcount_b), 32'd1);
    chk("wrap.line_end", 32'(line_end_b), 32'd1);
    chk("wrap.frame_start", 32'(frame_start_b), 32'd0);

    // Freeze mid-line for 100 clks, then resume by one pixel.
    adv_to(300, 1, 1);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
    chk("freeze.hcount", 32'(hcount_b), 32'd300);
    tick(1'b1, 1'b0);
    chk("resume.hcount", 32'(hcount_b), 32'd301);

    // Random spacing, then back-to-back strobes.
    adv_to(700, 2, 1);
    adv_to(700, 3, 2);
    chk("h700.hsync", 32'(hsync_b), 32'd0);

    // Reset inside hsync with pix_en high on the same edge.
    tick(1'b1, 1'b1);
    chk("midrst.hcount", 32'(hcount_b), 32'd799);
    chk("midrst.vcount", 32'(vcount_b), 32'd524);
    chk("midrst.syncs", 32'({hsync_b, vsync_b}), 32'd3);
    chk("midrst.video_on", 32'(video_on_b), 32'd0);
    chk("midrst.pulses", 32'({line_end_b, frame_start_b}), 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("restart.frame_start", 32'(frame_start_b), 32'd1);

    // Many small-raster frames under random and continuous strobes.
    for (int i = 0; i < 1500; i++) tick($urandom_range(0, 2) == 0, 1'b0);
    for (int i = 0; i < 500; i++) tick(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
